// File: rtl/convclk_pkg.sv
// Shared definitions for the convclk FIFO write-side blocks:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package convclk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so a 2-requester pointer is 1 bit wide
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/convclk_rrpick.sv
// Round-robin picker: rotates req so the requester after rrptr lands in
// bit 0, priority-encodes the rotated vector, then maps the winner back.
module convclk_rrpick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rrptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pickidx,
  output logic            anyreq
);

  logic [PW:0]       base;
  logic [2*NREQ-1:0] dbl_sh;
  logic [NREQ-1:0]   rot;
  int                off;
  int                idx;

  // Double-width rotate then lowest-set-bit priority encode
  always_comb begin
    base    = {1'b0, rrptr} + {{PW{1'b0}}, 1'b1};
    dbl_sh  = {req, req} >> base;
    rot     = dbl_sh[NREQ-1:0];
    anyreq  = |req;
    off     = 0;
    idx     = 0;
    pick    = '0;
    pickidx = '0;
    // scan downwards so the lowest set offset is the one that remains
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    idx = int'(base) + off;
    if (idx >= NREQ) idx = idx - NREQ;
    if (anyreq) begin
      pickidx = PW'(idx);
      for (int i = 0; i < NREQ; i++) begin
        pick[i] = (i == idx);
      end
    end
  end

endmodule

// File: rtl/convclk_ffwrarb.sv
// Write-side arbiter for the dual-clock Gray-pointer FIFO.
// Shares one FIFO write port among NREQ requesters with round-robin
// arbitration and sequences the write-side flush.
// Build option: CONVCLK_FFWRARB_PKTLOCK_EN holds a grant for a whole
// packet (until an acked word with reqeop); without it every acked word
// releases the grant and reqeop is ignored.
module convclk_ffwrarb
  import convclk_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 32,
  parameter int ADDRB    = 4,
  parameter int FLUSHCYC = 2
) (
  input  logic               wrclk,
  input  logic               wrrst_,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] reqdat,
  input  logic [NREQ-1:0]    reqeop,
  output logic [NREQ-1:0]    ack,
  input  logic               flushreq,
  output logic               flushdone,
  output logic               fifowr,
  output logic [DW-1:0]      fifodat,
  output logic               fifoflush,
  input  logic               fifofull,
  input  logic [ADDRB:0]     wrfifolen,
  output logic [NREQ-1:0]    gnt,
  output logic               busy
);

  localparam int PW = clog2(NREQ);

  state_t            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [PW-1:0]     rrptr_q;
  logic [3:0]        flushcnt_q;
  logic              flushpend_q;

  logic [NREQ-1:0]   pick;
  logic [PW-1:0]     pickidx;
  logic              anyreq;
  logic              cur_req;
  logic              grant_rel;
  logic              unused_in;

  convclk_rrpick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rrpick (
    .req     (req),
    .rrptr   (rrptr_q),
    .pick    (pick),
    .pickidx (pickidx),
    .anyreq  (anyreq)
  );

  // Zero-latency accept straight from the registered grant
  assign gnt     = gnt_q;
  assign ack     = gnt_q & req & {NREQ{~fifofull & (state_q == GRANT)}};
  assign fifowr  = |ack;
  assign cur_req = |(gnt_q & req);

`ifdef CONVCLK_FFWRARB_PKTLOCK_EN
  // Grant is held across the packet; a low req just stalls it
  assign grant_rel = fifowr & |(gnt_q & reqeop);
  assign unused_in = ^wrfifolen;
`else
  // Word-granular: any accepted word, or a requester that went quiet, releases
  assign grant_rel = fifowr | ~cur_req;
  assign unused_in = ^{wrfifolen, reqeop};
`endif

  assign fifoflush = (state_q == FLUSH);
  assign flushdone = (state_q == FLUSH) && (flushcnt_q == 4'(FLUSHCYC - 1));
  assign busy      = (state_q != IDLE);

  // Data mux selected by the one-hot grant; zero when nothing is granted
  always_comb begin
    fifodat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) fifodat = reqdat[i*DW +: DW];
    end
  end

  // Arbitration / flush FSM; re-arbitrates on the release edge so grants abut
  always_ff @(posedge wrclk or negedge wrrst_) begin
    if (!wrrst_) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rrptr_q     <= PW'(NREQ - 1);
      flushcnt_q  <= '0;
      flushpend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flushreq) begin
            state_q    <= FLUSH;
            flushcnt_q <= '0;
          end else if (anyreq) begin
            state_q <= GRANT;
            gnt_q   <= pick;
            rrptr_q <= pickidx;
          end
        end
        GRANT: begin
          if (grant_rel) begin
            if (flushreq || flushpend_q) begin
              state_q     <= FLUSH;
              gnt_q       <= '0;
              flushcnt_q  <= '0;
              flushpend_q <= 1'b0;
            end else if (anyreq) begin
              gnt_q   <= pick;
              rrptr_q <= pickidx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end else if (flushreq) begin
            flushpend_q <= 1'b1;
          end
        end
        FLUSH: begin
          // requests arriving here are absorbed by this flush
          if (flushdone) begin
            state_q <= IDLE;
          end else begin
            flushcnt_q <= flushcnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convclk_ffwrarb.sv
// Directed bench for convclk_ffwrarb: per-cycle vector table plus
// hand-written asynchronous-reset sequences.
module tb_convclk_ffwrarb;

  localparam int NREQ     = 4;
  localparam int DW       = 32;
  localparam int ADDRB    = 4;
  localparam int FLUSHCYC = 2;

  logic               wrclk;
  logic               wrrst_;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] reqdat;
  logic [NREQ-1:0]    reqeop;
  logic [NREQ-1:0]    ack;
  logic               flushreq;
  logic               flushdone;
  logic               fifowr;
  logic [DW-1:0]      fifodat;
  logic               fifoflush;
  logic               fifofull;
  logic [ADDRB:0]     wrfifolen;
  logic [NREQ-1:0]    gnt;
  logic               busy;

  convclk_ffwrarb #(
    .NREQ     (NREQ),
    .DW       (DW),
    .ADDRB    (ADDRB),
    .FLUSHCYC (FLUSHCYC)
  ) dut (
    .wrclk     (wrclk),
    .wrrst_    (wrrst_),
    .req       (req),
    .reqdat    (reqdat),
    .reqeop    (reqeop),
    .ack       (ack),
    .flushreq  (flushreq),
    .flushdone (flushdone),
    .fifowr    (fifowr),
    .fifodat   (fifodat),
    .fifoflush (fifoflush),
    .fifofull  (fifofull),
    .wrfifolen (wrfifolen),
    .gnt       (gnt),
    .busy      (busy)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  typedef struct {
    int       seq;
    logic [3:0] rq;
    logic [3:0] ep;
    logic       ff;
    logic       fr;
    logic [3:0] ak;
    logic [3:0] gn;
    logic       fl;
    logic       fd;
    logic       bz;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_pass;

  task automatic add(input int s, input logic [3:0] rq, input logic [3:0] ep,
                     input logic ff, input logic fr, input logic [3:0] ak,
                     input logic [3:0] gn, input logic fl, input logic fd,
                     input logic bz);
    vec_t v;
    v.seq = s; v.rq = rq; v.ep = ep; v.ff = ff; v.fr = fr;
    v.ak = ak; v.gn = gn; v.fl = fl; v.fd = fd; v.bz = bz;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] dat_of(input int i);
    return 32'hD000_0001 + i * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] exp_dat(input logic [3:0] g);
    logic [31:0] d;
    d = 32'h0;
    for (int i = 0; i < NREQ; i++) if (g[i]) d = dat_of(i);
    return d;
  endfunction

  task automatic do_reset();
    req = '0; reqeop = '0; fifofull = 1'b0; flushreq = 1'b0;
    wrrst_ = 1'b0;
    #1;
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst ack", 32'(ack), 32'h0);
    chk("rst fifowr", 32'(fifowr), 32'h0);
    chk("rst fifodat", fifodat, 32'h0);
    chk("rst fifoflush", 32'(fifoflush), 32'h0);
    chk("rst flushdone", 32'(flushdone), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    repeat (2) @(negedge wrclk);
    wrrst_ = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    wrrst_ = 1'b0; req = '0; reqeop = '0; fifofull = 1'b0; flushreq = 1'b0;
    wrfifolen = '0;
    for (int i = 0; i < NREQ; i++) reqdat[i*DW +: DW] = dat_of(i);

    // seq 1: all requesting, single-word packets -> 0,1,2,3,0 with no gaps
    add(1, 4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    add(1, 4'hF, 4'hF, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(1, 4'hF, 4'hF, 0, 0, 4'h2, 4'h2, 0, 0, 1);
    add(1, 4'hF, 4'hF, 0, 0, 4'h4, 4'h4, 0, 0, 1);
    add(1, 4'hF, 4'hF, 0, 0, 4'h8, 4'h8, 0, 0, 1);
    add(1, 4'hF, 4'hF, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    // seq 2: req0 3-word packet while req1 also requests
    add(2, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
`ifdef CONVCLK_FFWRARB_PKTLOCK_EN
    add(2, 4'h3, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(2, 4'h3, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(2, 4'h3, 4'h3, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(2, 4'h3, 4'h3, 0, 0, 4'h2, 4'h2, 0, 0, 1);
    add(2, 4'h3, 4'h3, 0, 0, 4'h1, 4'h1, 0, 0, 1);
`else
    add(2, 4'h3, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(2, 4'h3, 4'h0, 0, 0, 4'h2, 4'h2, 0, 0, 1);
    add(2, 4'h3, 4'h3, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(2, 4'h3, 4'h3, 0, 0, 4'h2, 4'h2, 0, 0, 1);
    add(2, 4'h3, 4'h3, 0, 0, 4'h1, 4'h1, 0, 0, 1);
`endif
    // seq 3: fifofull for 5 cycles mid-packet
    add(3, 4'h1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    add(3, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    for (int k = 0; k < 5; k++) add(3, 4'h1, 4'h0, 1, 0, 4'h0, 4'h1, 0, 0, 1);
    add(3, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    // seq 4: flushreq during word 2 of a 4-word packet
    add(4, 4'h1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
`ifdef CONVCLK_FFWRARB_PKTLOCK_EN
    add(4, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(4, 4'h1, 4'h0, 0, 1, 4'h1, 4'h1, 0, 0, 1);
    add(4, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(4, 4'h1, 4'h1, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(4, 4'h1, 4'h1, 0, 1, 4'h0, 4'h0, 1, 0, 1);
    add(4, 4'h1, 4'h1, 0, 0, 4'h0, 4'h0, 1, 1, 1);
    add(4, 4'h1, 4'h1, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    add(4, 4'h1, 4'h1, 0, 0, 4'h1, 4'h1, 0, 0, 1);
`else
    add(4, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(4, 4'h1, 4'h0, 0, 1, 4'h1, 4'h1, 0, 0, 1);
    add(4, 4'h1, 4'h0, 0, 1, 4'h0, 4'h0, 1, 0, 1);
    add(4, 4'h1, 4'h0, 0, 0, 4'h0, 4'h0, 1, 1, 1);
    add(4, 4'h1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    add(4, 4'h1, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
`endif
    // seq 5: flush from IDLE, latency and length
    add(5, 4'h0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    add(5, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0, 1);
    add(5, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 1, 1, 1);
    add(5, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    // seq 6: granted requester drops req
`ifdef CONVCLK_FFWRARB_PKTLOCK_EN
    add(6, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    add(6, 4'h3, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(6, 4'h2, 4'h0, 0, 0, 4'h0, 4'h1, 0, 0, 1);
    add(6, 4'h2, 4'h0, 0, 0, 4'h0, 4'h1, 0, 0, 1);
    add(6, 4'h3, 4'h1, 0, 0, 4'h1, 4'h1, 0, 0, 1);
    add(6, 4'h2, 4'h2, 0, 0, 4'h2, 4'h2, 0, 0, 1);
`else
    add(6, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    add(6, 4'h2, 4'h0, 0, 0, 4'h0, 4'h1, 0, 0, 1);
    add(6, 4'h2, 4'h0, 0, 0, 4'h2, 4'h2, 0, 0, 1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].seq != tbl[i-1].seq) do_reset();
      req = tbl[i].rq; reqeop = tbl[i].ep; fifofull = tbl[i].ff; flushreq = tbl[i].fr;
      #1;
      chk($sformatf("s%0d r%0d ack", tbl[i].seq, i), 32'(ack), 32'(tbl[i].ak));
      chk($sformatf("s%0d r%0d gnt", tbl[i].seq, i), 32'(gnt), 32'(tbl[i].gn));
      chk($sformatf("s%0d r%0d fifowr", tbl[i].seq, i), 32'(fifowr), 32'(|tbl[i].ak));
      chk($sformatf("s%0d r%0d fifodat", tbl[i].seq, i), fifodat, exp_dat(tbl[i].gn));
      chk($sformatf("s%0d r%0d fifoflush", tbl[i].seq, i), 32'(fifoflush), 32'(tbl[i].fl));
      chk($sformatf("s%0d r%0d flushdone", tbl[i].seq, i), 32'(flushdone), 32'(tbl[i].fd));
      chk($sformatf("s%0d r%0d busy", tbl[i].seq, i), 32'(busy), 32'(tbl[i].bz));
      @(negedge wrclk);
    end

    // asynchronous reset in the middle of a flush
    do_reset();
    flushreq = 1'b1;
    @(negedge wrclk);
    flushreq = 1'b0;
    #1;
    chk("arst pre fifoflush", 32'(fifoflush), 32'h1);
    #2;
    wrrst_ = 1'b0;
    #1;
    chk("arst fifoflush", 32'(fifoflush), 32'h0);
    chk("arst flushdone", 32'(flushdone), 32'h0);
    chk("arst gnt", 32'(gnt), 32'h0);
    chk("arst busy", 32'(busy), 32'h0);
    @(negedge wrclk);
    wrrst_ = 1'b1; req = 4'h4; reqeop = 4'h4;
    #1;
    chk("post-arst c1 gnt", 32'(gnt), 32'h0);
    @(negedge wrclk);
    #1;
    chk("post-arst c2 gnt", 32'(gnt), 32'h4);
    chk("post-arst c2 ack", 32'(ack), 32'h4);
    chk("post-arst c2 fifodat", fifodat, dat_of(2));

    // asynchronous reset while a grant is active
    #2;
    wrrst_ = 1'b0;
    #1;
    chk("arst mid-pkt gnt", 32'(gnt), 32'h0);
    chk("arst mid-pkt fifowr", 32'(fifowr), 32'h0);
    @(negedge wrclk);
    wrrst_ = 1'b1; req = '0;
    @(negedge wrclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
